prim_secded_inv_39_32_enc_pipe: RTL

- Streaming encoder for the inverted Hsiao SECDED (39,32) code: accepts 32-bit data words over valid/ready and emits 39-bit inverted codewords over valid/ready.
- Sits on memory/bus write paths, feeding storage that is later checked by the matching (39,32) inverted decoder.
- 1-cycle latency, full throughput, registered in_ready_o through a 2-entry skid buffer.
- Per-beat fault-injection XOR for DV/FI campaigns; saturating count of delivered codewords.

---
 rtl/prim_secded_pkg.sv | 28 ++
 rtl/prim_secded_inv_39_32_enc.sv | 11 +
 rtl/prim_secded_inv_39_32_enc_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/prim_secded_pkg.sv
// Constants and the reference encode function for the inverted Hsiao
// SECDED (39,32) code shared by the encoder and pipe.
package prim_secded_pkg;

  // Row k selects the data bits whose parity forms check bit k (cw[32+k]).
  localparam logic [6:0][31:0] SecdedInv3932Masks = {
    32'h98505586,
    32'h2DCC624C,
    32'hC2C1323B,
    32'h31234ED1,
    32'h413D89AA,
    32'hDEBA8050,
    32'h2606BD25
  };

  // Check bits 1, 3 and 5 are stored inverted so all-zero is not a codeword.
  localparam logic [38:0] SecdedInv3932InvConst = 39'h2A00000000;

  function automatic logic [38:0] prim_secded_inv_39_32_enc_f(input logic [31:0] data);
    logic [38:0] cw;
    cw = {7'b0, data};
    for (int unsigned k = 0; k < 7; k++) begin
      cw[32+k] = ^(data & SecdedInv3932Masks[k]);
    end
    return cw ^ SecdedInv3932InvConst;
  endfunction

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// Combinational inverted SECDED (39,32) encoder.
module prim_secded_inv_39_32_enc
  import prim_secded_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  assign data_o = prim_secded_inv_39_32_enc_f(data_i);

endmodule

// File: rtl/prim_secded_inv_39_32_enc_pipe.sv
// Streaming inverted SECDED (39,32) encoder: 1-cycle latency, full
// throughput, 2-entry skid buffer with a registered input ready,
// per-beat fault injection and a saturating delivered-beat counter.
module prim_secded_inv_39_32_enc_pipe #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     data_i,
  input  logic [38:0]     inj_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [38:0]     data_o,
  output logic [CntW-1:0] beat_cnt_o
);

  logic [38:0]     enc_cw;
  logic [38:0]     in_cw;
  logic [38:0]     main_q, main_d;
  logic [38:0]     skid_q, skid_d;
  logic            main_vld_q, main_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic [CntW-1:0] beat_cnt_q;
  logic            acc, pop;

  prim_secded_inv_39_32_enc u_enc (
    .data_i (data_i),
    .data_o (enc_cw)
  );

  assign in_cw = enc_cw ^ inj_i;

  // Ready depends only on skid occupancy, so it comes straight from a flop.
  assign in_ready_o  = ~skid_vld_q;
  assign acc         = in_valid_i & ~skid_vld_q;
  assign pop         = main_vld_q & out_ready_i;
  assign out_valid_o = main_vld_q;
  assign data_o      = main_q;
  assign beat_cnt_o  = beat_cnt_q;

  // Next-state for the main/skid pair; skid is only ever occupied while main is.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q) begin
      if (acc) begin
        main_d     = in_cw;
        main_vld_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d = in_cw;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = in_cw;
      skid_vld_d = 1'b1;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else if (pop && (beat_cnt_q != '1)) begin
      beat_cnt_q <= beat_cnt_q + CntW'(1);
    end
  end

endmodule
